// File: rtl/prf_pkg.sv
// Shared physical-register-file definitions for the reclaim path.
package prf_pkg;

    localparam int PRF_TAG_W = 6;

    typedef logic [PRF_TAG_W-1:0] prf_tag_t;

    localparam prf_tag_t PRF_ZERO_TAG = '0;

endpackage : prf_pkg

// File: rtl/reclaim_queue.sv
// Staging queue for one free-list parity: two ordered pushes and one pop
// per cycle, circular storage with wrap-bit pointers and a free-slot count.
module reclaim_queue
    import prf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_push0_en,
    input  prf_tag_t                 i_push0_data,
    input  logic                     i_push1_en,
    input  prf_tag_t                 i_push1_data,
    input  logic                     i_pop_en,
    output prf_tag_t                 o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count;
    prf_tag_t      mem_q [DEPTH];
    prf_tag_t      mem_d [DEPTH];

    // Next-state: push0 lands first, push1 in the slot after it; pop advances the read pointer.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (i_push0_en) begin
            mem_d[wr_ptr_d[AW-1:0]] = i_push0_data;
            wr_ptr_d                = wr_ptr_d + PW'(1);
        end
        if (i_push1_en) begin
            mem_d[wr_ptr_d[AW-1:0]] = i_push1_data;
            wr_ptr_d                = wr_ptr_d + PW'(1);
        end
        rd_ptr_d = rd_ptr_q + PW'(i_pop_en);
    end

    // State registers; reset discards anything staged.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign count      = wr_ptr_q - rd_ptr_q;
    assign o_free_cnt = PW'(DEPTH) - count;
    assign o_empty    = (wr_ptr_q == rd_ptr_q);
    assign o_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_head     = mem_q[rd_ptr_q[AW-1:0]];

endmodule : reclaim_queue

// File: rtl/prf_reclaim.sv
// Commit-side reclaim unit: filters tag 0, routes retired tags by parity into
// per-parity staging queues and drains each queue into its free list.
// Optional feature macro PRF_RECLAIM_BYPASS_EN: an incoming tag skips an empty
// queue and is written to a non-full free list in the acceptance cycle.
module prf_reclaim
    import prf_pkg::*;
#(
    parameter int STAGE_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_resetn,
    input  logic [1:0]     i_commit_valid,
    input  prf_tag_t       i_commit_tag0,
    input  prf_tag_t       i_commit_tag1,
    output logic           o_commit_ready,
    output logic           o_even_wr_en,
    output prf_tag_t       o_even_wr_data,
    input  logic           i_even_full,
    output logic           o_odd_wr_en,
    output prf_tag_t       o_odd_wr_data,
    input  logic           i_odd_full
);

    localparam int FW = $clog2(STAGE_DEPTH) + 1;

    logic                       accept;
    logic [1:0]                 slot_live;
    logic [1:0]                 space_ok;
    logic [1:0]                 wr_en_all;
    logic [1:0][PRF_TAG_W-1:0]  wr_data_all;

    // Ready depends only on staging occupancy so commit sees no path from its own inputs.
    assign o_commit_ready = i_resetn & space_ok[0] & space_ok[1];
    assign accept         = o_commit_ready & (|i_commit_valid);
    assign slot_live[0]   = accept & i_commit_valid[0] & (i_commit_tag0 != PRF_ZERO_TAG);
    assign slot_live[1]   = accept & i_commit_valid[1] & (i_commit_tag1 != PRF_ZERO_TAG);

    for (genvar p = 0; p < 2; p++) begin : g_par
        localparam logic PAR = 1'(p);

        logic       first_en, second_en;
        prf_tag_t   first_tag, second_tag;
        logic       push0_en, push1_en;
        prf_tag_t   push0_data, push1_data;
        logic       pop_en, wr_en;
        prf_tag_t   wr_data;
        logic       list_full;
        prf_tag_t   q_head;
        logic       q_empty, q_full;
        logic [FW-1:0] q_free;
`ifdef PRF_RECLAIM_BYPASS_EN
        logic       bypass;
`endif

        assign list_full = (p == 0) ? i_even_full : i_odd_full;

        // Collect this parity's live tags in age order (older slot first).
        always_comb begin
            first_en   = 1'b0;
            first_tag  = '0;
            second_en  = 1'b0;
            second_tag = '0;
            if (slot_live[0] && (i_commit_tag0[0] == PAR)) begin
                first_en  = 1'b1;
                first_tag = i_commit_tag0;
            end
            if (slot_live[1] && (i_commit_tag1[0] == PAR)) begin
                if (first_en) begin
                    second_en  = 1'b1;
                    second_tag = i_commit_tag1;
                end else begin
                    first_en  = 1'b1;
                    first_tag = i_commit_tag1;
                end
            end
        end

        // Decide what is enqueued and what drives the free-list write port.
        always_comb begin
            pop_en = ~q_empty & ~list_full;
`ifdef PRF_RECLAIM_BYPASS_EN
            bypass     = q_empty & ~list_full & first_en;
            push0_en   = bypass ? second_en : first_en;
            push0_data = bypass ? second_tag : first_tag;
            push1_en   = bypass ? 1'b0 : second_en;
            push1_data = second_tag;
            wr_en      = pop_en | bypass;
            wr_data    = bypass ? first_tag : (pop_en ? q_head : '0);
`else
            push0_en   = first_en;
            push0_data = first_tag;
            push1_en   = second_en;
            push1_data = second_tag;
            wr_en      = pop_en;
            wr_data    = pop_en ? q_head : '0;
`endif
        end

        reclaim_queue #(
            .DEPTH (STAGE_DEPTH)
        ) u_queue (
            .i_clk        (i_clk),
            .i_resetn     (i_resetn),
            .i_push0_en   (push0_en),
            .i_push0_data (push0_data),
            .i_push1_en   (push1_en),
            .i_push1_data (push1_data),
            .i_pop_en     (pop_en),
            .o_head       (q_head),
            .o_empty      (q_empty),
            .o_full       (q_full),
            .o_free_cnt   (q_free)
        );

        assign space_ok[p]    = ~q_full & (q_free >= FW'(2));
        assign wr_en_all[p]   = wr_en;
        assign wr_data_all[p] = wr_data;
    end

    assign o_even_wr_en   = wr_en_all[0];
    assign o_even_wr_data = wr_data_all[0];
    assign o_odd_wr_en    = wr_en_all[1];
    assign o_odd_wr_data  = wr_data_all[1];

endmodule : prf_reclaim

// File: tb/tb_prf_reclaim.sv
// Bench for prf_reclaim: directed scenarios then randomized commit traffic,
// checked against a per-parity queue model of staged tags.
module tb_prf_reclaim;
    import prf_pkg::*;

    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       i_resetn = 1'b0;
    logic [1:0] i_commit_valid = 2'b00;
    prf_tag_t   i_commit_tag0 = '0;
    prf_tag_t   i_commit_tag1 = '0;
    logic       o_commit_ready;
    logic       o_even_wr_en;
    prf_tag_t   o_even_wr_data;
    logic       i_even_full = 1'b0;
    logic       o_odd_wr_en;
    prf_tag_t   o_odd_wr_data;
    logic       i_odd_full = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [5:0] mq [2][$];

    prf_reclaim #(.STAGE_DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_commit_valid (i_commit_valid),
        .i_commit_tag0  (i_commit_tag0),
        .i_commit_tag1  (i_commit_tag1),
        .o_commit_ready (o_commit_ready),
        .o_even_wr_en   (o_even_wr_en),
        .o_even_wr_data (o_even_wr_data),
        .i_even_full    (i_even_full),
        .o_odd_wr_en    (o_odd_wr_en),
        .o_odd_wr_data  (o_odd_wr_data),
        .i_odd_full     (i_odd_full)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: at each falling edge compare outputs against the model, then update it.
    always @(negedge i_clk) begin
        logic [5:0] inc [$];
        logic       exp_ready;
        logic       exp_en;
        logic [5:0] exp_data;
        logic       full_p;
        logic       act_en;
        logic [5:0] act_data;
        if (!i_resetn) begin
            mq[0].delete();
            mq[1].delete();
            check("reset_ready", int'(o_commit_ready), 0);
            check("reset_even_en", int'(o_even_wr_en), 0);
            check("reset_odd_en", int'(o_odd_wr_en), 0);
            check("reset_even_data", int'(o_even_wr_data), 0);
            check("reset_odd_data", int'(o_odd_wr_data), 0);
        end else begin
            exp_ready = ((DEPTH - mq[0].size()) >= 2) && ((DEPTH - mq[1].size()) >= 2);
            check("ready", int'(o_commit_ready), int'(exp_ready));
            for (int p = 0; p < 2; p++) begin
                inc.delete();
                if (exp_ready && (i_commit_valid != 2'b00)) begin
                    if (i_commit_valid[0] && i_commit_tag0 != 0 && int'(i_commit_tag0[0]) == p)
                        inc.push_back(i_commit_tag0);
                    if (i_commit_valid[1] && i_commit_tag1 != 0 && int'(i_commit_tag1[0]) == p)
                        inc.push_back(i_commit_tag1);
                end
                full_p   = (p == 0) ? i_even_full : i_odd_full;
                act_en   = (p == 0) ? o_even_wr_en : o_odd_wr_en;
                act_data = (p == 0) ? o_even_wr_data : o_odd_wr_data;
                exp_en   = 1'b0;
                exp_data = '0;
`ifdef PRF_RECLAIM_BYPASS_EN
                if (mq[p].size() == 0 && !full_p && inc.size() > 0) begin
                    exp_en   = 1'b1;
                    exp_data = inc.pop_front();
                end else
`endif
                if (mq[p].size() > 0 && !full_p) begin
                    exp_en   = 1'b1;
                    exp_data = mq[p].pop_front();
                end
                check((p == 0) ? "even_wr_en" : "odd_wr_en", int'(act_en), int'(exp_en));
                check((p == 0) ? "even_wr_data" : "odd_wr_data", int'(act_data), int'(exp_data));
                foreach (inc[i]) mq[p].push_back(inc[i]);
            end
        end
    end

    task automatic drive(input logic rstn, input logic [1:0] v, input int t0, input int t1,
                         input logic ef, input logic of);
        @(posedge i_clk);
        #1;
        i_resetn       = rstn;
        i_commit_valid = v;
        i_commit_tag0  = 6'(t0);
        i_commit_tag1  = 6'(t1);
        i_even_full    = ef;
        i_odd_full     = of;
    endtask

    function automatic int rand_tag();
        int t;
        t = int'($urandom_range(0, 63));
        if ($urandom_range(0, 15) == 0) t = 0;
        return t;
    endfunction

    initial begin
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        // Mixed-parity pair
        drive(1'b1, 2'b11, 34, 35, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        // Same-parity pairs back to back
        drive(1'b1, 2'b11, 36, 38, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 40, 42, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        // Odd free list full while odd tags stage
        drive(1'b1, 2'b11, 33, 37, 1'b0, 1'b1);
        drive(1'b1, 2'b11, 39, 41, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        // Tag 0 is never freed
        drive(1'b1, 2'b01, 0, 5, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 7, 0, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        // Reset with tags staged mid-drain
        drive(1'b1, 2'b11, 2, 4, 1'b1, 1'b0);
        drive(1'b1, 2'b01, 6, 0, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        // Randomized traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            logic rn;
            rn = !(n == 900 || n == 901);
            drive(rn, 2'($urandom_range(0, 3)), rand_tag(), rand_tag(),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
        end
        // Drain
        for (int i = 0; i < 12; i++) drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge i_clk);
        #1;
        check("drained_even", mq[0].size(), 0);
        check("drained_odd", mq[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prf_reclaim
